// File: rtl/fhew_decomp_pkg.sv
// Shared defaults, offset constant and FSM state type for the signed-digit
// decomposition sequencer (sd_decomp_sched) and its digit extractor.
// Ports: none (package).
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 27
`endif

package fhew_decomp_pkg;

   localparam int unsigned DATA_W_DEF = `DATA_SIZE_ARB;
   localparam int unsigned Q_DEF      = 134176769;
   localparam int unsigned LOG_N_DEF  = 10;
   localparam int unsigned LOG_BG_DEF = 7;
   localparam int unsigned DIGITS_DEF = 4;

   // O = sum_k (Bg/2)*Bg^k; adding it makes every base-Bg field of the
   // lifted value non-negative so digits are plain field extracts minus Bg/2.
   function automatic logic [63:0] offset_o(input int unsigned log_bg,
                                            input int unsigned digits);
      logic [63:0] o;
      o = '0;
      for (int unsigned k = 0; k < digits; k++) begin
         o = o + (64'(1) << (log_bg * k + log_bg - 1));
      end
      return o;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/sd_decomp_sched_digit.sv
// sd_digit_extract: combinational centred lift, offset add and digit select.
// Ports:
//   x     in  DATA_W  coefficient in [0, Q)
//   d     in  DW      digit index
//   digit out LOG_BG  signed digit in [-Bg/2, Bg/2-1]
module sd_digit_extract
   import fhew_decomp_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned Q      = Q_DEF,
   parameter int unsigned LOG_BG = LOG_BG_DEF,
   parameter int unsigned DIGITS = DIGITS_DEF,
   localparam int unsigned DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic [DATA_W-1:0] x,
   input  logic [DW-1:0]     d,
   output logic [LOG_BG-1:0] digit
);

   localparam int unsigned SW = DIGITS * LOG_BG;
   localparam int unsigned AW = SW + 1;

   localparam logic [AW-1:0]     Q_A     = AW'(Q);
   localparam logic [AW-1:0]     HALF_Q  = AW'((Q - 1) / 2);
   localparam logic [AW-1:0]     OFF     = AW'(offset_o(LOG_BG, DIGITS));
   localparam logic [LOG_BG-1:0] HALF_BG = LOG_BG'(32'(1) << (LOG_BG - 1));

   logic [AW-1:0] s;
   logic [SW-1:0] u;

   // Field minus Bg/2 wraps mod 2^LOG_BG into the two's-complement digit.
   always_comb begin
      s     = (AW'(x) <= HALF_Q) ? AW'(x) : AW'(x) - Q_A;
      u     = SW'(s + OFF);
      digit = LOG_BG'(u >> (int'(d) * LOG_BG)) - HALF_BG;
   end

endmodule

// File: rtl/sd_decomp_sched.sv
// sd_decomp_sched: walks the coefficient RAM digit-major and streams one
// signed base-2^LOG_BG digit per accepted valid/ready transfer.
// Optional macro SD_DECOMP_PERF_CNT_EN adds the stall_cnt output.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start / busy / done frame control (done is a one-cycle pulse)
//   mem_rd_en/addr/data coefficient RAM read port (data valid next cycle)
//   dig_valid/ready     digit stream handshake
//   dig_data/idx/coef_idx/last/frame_last  digit payload
//   stall_cnt           (macro only) valid-but-not-ready cycles per frame
// LOG_N=0 and DIGITS=1 keep 1-bit index ports.
module sd_decomp_sched
   import fhew_decomp_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned Q      = Q_DEF,
   parameter int unsigned LOG_N  = LOG_N_DEF,
   parameter int unsigned LOG_BG = LOG_BG_DEF,
   parameter int unsigned DIGITS = DIGITS_DEF,
   localparam int unsigned AW    = (LOG_N > 0) ? LOG_N : 1,
   localparam int unsigned DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [AW-1:0]     mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              dig_valid,
   input  logic              dig_ready,
   output logic [LOG_BG-1:0] dig_data,
   output logic [DW-1:0]     dig_idx,
   output logic [AW-1:0]     dig_coef_idx,
   output logic              dig_last,
`ifdef SD_DECOMP_PERF_CNT_EN
   output logic [31:0]       stall_cnt,
`endif
   output logic              dig_frame_last
);

   localparam logic [AW-1:0] I_LAST = AW'((32'(1) << LOG_N) - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);

   state_e            state;
   logic [AW-1:0]     rd_i;
   logic [DW-1:0]     rd_d;
   logic              pend;
   logic [AW-1:0]     pend_i;
   logic [DW-1:0]     pend_d;
   logic              load;
   logic              xfer;
   logic [LOG_BG-1:0] digit_c;

   // Issue a read only when the word it returns has somewhere to go.
   always_comb begin
      load      = pend && (!dig_valid || dig_ready);
      xfer      = dig_valid && dig_ready;
      mem_rd_en = (state == ST_RUN) && (!pend || load);
   end

   assign mem_rd_addr = rd_i;

   sd_digit_extract #(
      .DATA_W (DATA_W),
      .Q      (Q),
      .LOG_BG (LOG_BG),
      .DIGITS (DIGITS)
   ) u_extract (
      .x     (mem_rd_data),
      .d     (pend_d),
      .digit (digit_c)
   );

   // Controller: FSM, read counters, pending tag and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         rd_i           <= '0;
         rd_d           <= '0;
         pend           <= 1'b0;
         pend_i         <= '0;
         pend_d         <= '0;
         dig_valid      <= 1'b0;
         dig_data       <= '0;
         dig_idx        <= '0;
         dig_coef_idx   <= '0;
         dig_last       <= 1'b0;
         dig_frame_last <= 1'b0;
`ifdef SD_DECOMP_PERF_CNT_EN
         stall_cnt      <= '0;
`endif
      end else begin
         done <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
                  rd_i  <= '0;
                  rd_d  <= '0;
               end
            end
            ST_RUN: begin
               if (mem_rd_en && (rd_i == I_LAST) && (rd_d == D_LAST)) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (xfer && dig_frame_last) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase

         // Read counters; the issued index is tagged onto the pending word.
         if (mem_rd_en) begin
            pend_i <= rd_i;
            pend_d <= rd_d;
            if (rd_i == I_LAST) begin
               rd_i <= '0;
               rd_d <= (rd_d == D_LAST) ? '0 : rd_d + DW'(1);
            end else begin
               rd_i <= rd_i + AW'(1);
            end
         end

         if (mem_rd_en) begin
            pend <= 1'b1;
         end else if (load) begin
            pend <= 1'b0;
         end

         if (load) begin
            dig_valid      <= 1'b1;
            dig_data       <= digit_c;
            dig_idx        <= pend_d;
            dig_coef_idx   <= pend_i;
            dig_last       <= (pend_i == I_LAST);
            dig_frame_last <= (pend_i == I_LAST) && (pend_d == D_LAST);
         end else if (xfer) begin
            dig_valid <= 1'b0;
         end

`ifdef SD_DECOMP_PERF_CNT_EN
         if ((state == ST_IDLE) && start) begin
            stall_cnt <= '0;
         end else if ((state != ST_IDLE) && dig_valid && !dig_ready &&
                      (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_sd_decomp_sched.sv
// Directed bench for sd_decomp_sched at default parameters: zero frame at
// full throughput, random frame with 50% ready and hand-checked special
// coefficients, reset abort, and a stalled frame (stall_cnt under the macro).
module tb_sd_decomp_sched;

   localparam int     N      = 1024;
   localparam int     DIGITS = 4;
   localparam int     NX     = N * DIGITS;
   localparam longint QL     = 134176769;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        dig_ready = 1'b0;
   logic        busy, done, mem_rd_en, dig_valid, dig_last, dig_frame_last;
   logic [9:0]  mem_rd_addr, dig_coef_idx;
   logic [26:0] mem_rd_data = '0;
   logic [6:0]  dig_data;
   logic [1:0]  dig_idx;
`ifdef SD_DECOMP_PERF_CNT_EN
   logic [31:0] stall_cnt;
`endif

   logic [26:0] mem [N];

   sd_decomp_sched dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .busy           (busy),
      .done           (done),
      .mem_rd_en      (mem_rd_en),
      .mem_rd_addr    (mem_rd_addr),
      .mem_rd_data    (mem_rd_data),
      .dig_valid      (dig_valid),
      .dig_ready      (dig_ready),
      .dig_data       (dig_data),
      .dig_idx        (dig_idx),
      .dig_coef_idx   (dig_coef_idx),
      .dig_last       (dig_last),
`ifdef SD_DECOMP_PERF_CNT_EN
      .stall_cnt      (stall_cnt),
`endif
      .dig_frame_last (dig_frame_last)
   );

   always #5 clk = ~clk;

   // RAM model: one-cycle read latency, output held when not reading.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint lift(input longint x);
      return (x <= (QL - 1) / 2) ? x : x - QL;
   endfunction

   // Balanced base-128 digits in [-64, 63], least significant first.
   function automatic longint ref_dig(input longint x, input int d);
      longint s, r;
      s = lift(x);
      r = 0;
      for (int k = 0; k <= d; k++) begin
         r = ((s % 128) + 128) % 128;
         if (r >= 64) r = r - 128;
         s = (s - r) / 128;
      end
      return r;
   endfunction

   int          ready_mode = 0;
   int          stall_left = 0;
   bit          stall_arm = 0;
   bit          stall_win = 0;
   bit          start_req = 0;
   int          exp_i, exp_d, n_xfer, done_cnt, cyc, done_cyc;
   bit          lat_arm = 0;
   bit          held = 0;
   logic [20:0] h_vec;
   longint      rec [N];
   longint      cap [3][4];

   task automatic monitor();
      logic [20:0] vec;
      longint      dg;
      vec = {dig_data, dig_idx, dig_coef_idx, dig_last, dig_frame_last};
      if (start && !busy) begin
         cyc = 0;
         lat_arm = 1;
      end else begin
         cyc++;
      end
      // start cycle + 2 startup cycles before the first digit shows.
      if (lat_arm && dig_valid) begin
         check("start_lat", cyc, 3);
         lat_arm = 0;
      end
      if (stall_win) check("stall_no_read", mem_rd_en, 0);
      if (held) begin
         check("hold_valid", dig_valid, 1);
         check("hold_payload", vec, h_vec);
      end
      if (dig_valid && dig_ready) begin
         dg = longint'($signed(dig_data));
         check("dig_data", dg, ref_dig(longint'(mem[exp_i]), exp_d));
         check("dig_idx", dig_idx, exp_d);
         check("coef_idx", dig_coef_idx, exp_i);
         check("last", dig_last, (exp_i == N - 1) ? 1 : 0);
         check("frame_last", dig_frame_last,
               (exp_i == N - 1 && exp_d == DIGITS - 1) ? 1 : 0);
         rec[exp_i] += dg * (longint'(1) << (7 * exp_d));
         if (exp_d < DIGITS) begin
            if (exp_i == 0) cap[0][exp_d] = dg;
            if (exp_i == 5) cap[1][exp_d] = dg;
            if (exp_i == 6) cap[2][exp_d] = dg;
         end
         n_xfer++;
         if (exp_i == N - 1) begin
            exp_i = 0;
            exp_d++;
         end else begin
            exp_i++;
         end
         held = 0;
      end else if (dig_valid) begin
         held = 1;
         h_vec = vec;
      end else begin
         held = 0;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         check("done_xfers", n_xfer, NX);
         check("done_busy", busy, 0);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      monitor();
      if (stall_arm && n_xfer == 100) begin
         stall_left = 10;
         stall_arm = 0;
      end
      @(posedge clk);
      #1;
      start = start_req;
      start_req = 0;
      if (stall_left > 0) begin
         dig_ready = 1'b0;
         stall_left--;
         stall_win = 1;
      end else begin
         stall_win = 0;
         dig_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
   endtask

   task automatic frame_start(input int mode);
      exp_i = 0;
      exp_d = 0;
      n_xfer = 0;
      done_cnt = 0;
      held = 0;
      for (int i = 0; i < N; i++) rec[i] = 0;
      ready_mode = mode;
      start_req = 1;
      cycle();
   endtask

   task automatic wait_done(input int bound);
      int k = 0;
      while (done_cnt == 0 && k < bound) begin
         cycle();
         k++;
      end
      if (done_cnt == 0) check("done_timeout", 0, 1);
   endtask

   task automatic wait_xfer(input int n, input int bound);
      int k = 0;
      while (n_xfer < n && k < bound) begin
         cycle();
         k++;
      end
      if (n_xfer < n) check("xfer_timeout", n_xfer, n);
   endtask

   task automatic reset_checks(input string pfx);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_done"}, done, 0);
      check({pfx, "_rd_en"}, mem_rd_en, 0);
      check({pfx, "_valid"}, dig_valid, 0);
      check({pfx, "_data"}, dig_data, 0);
      check({pfx, "_idx"}, dig_idx, 0);
      check({pfx, "_coef"}, dig_coef_idx, 0);
      check({pfx, "_last"}, dig_last, 0);
      check({pfx, "_flast"}, dig_frame_last, 0);
`ifdef SD_DECOMP_PERF_CNT_EN
      check({pfx, "_stall"}, stall_cnt, 0);
`endif
   endtask

   task automatic randomize_mem();
      for (int i = 0; i < N; i++) mem[i] = 27'($urandom_range(0, 32'(QL - 1)));
   endtask

   longint spec_tab [3][4] = '{'{-64, 1, 0, 0}, '{-1, 0, 0, 0}, '{1, 0, 0, 0}};

   initial begin
      for (int i = 0; i < N; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_checks("rst");
      rst_n = 1'b1;
      repeat (2) cycle();

      // All-zero frame at full throughput.
      frame_start(0);
      wait_done(6000);
      check("a_cycles", done_cyc, NX + 3);
      repeat (5) cycle();
      check("a_done_once", done_cnt, 1);

      // Random frame with special coefficients, 50% ready, start while busy.
      randomize_mem();
      mem[0] = 27'd64;
      mem[5] = 27'(QL - 1);
      mem[6] = 27'd1;
      mem[N - 2] = 27'((QL + 1) / 2);
      mem[N - 1] = 27'((QL - 1) / 2);
      frame_start(1);
      wait_xfer(1500, 8000);
      start_req = 1;
      cycle();
      cycle();
      check("b_busy_kept", busy, 1);
      wait_done(20000);
      repeat (5) cycle();
      check("b_done_once", done_cnt, 1);
      for (int r = 0; r < 3; r++)
         for (int d = 0; d < DIGITS; d++)
            check($sformatf("spec_r%0d_d%0d", r, d), cap[r][d], spec_tab[r][d]);
      for (int i = 0; i < N; i++) check("recon", rec[i], lift(longint'(mem[i])));

      // Reset at transfer 2000 aborts the frame without a done pulse.
      randomize_mem();
      frame_start(1);
      wait_xfer(2000, 10000);
      rst_n = 1'b0;
      #1;
      reset_checks("abort");
      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (20) cycle();
      check("abort_no_done", done_cnt, 0);

      // Fresh frame from d=0,i=0 with one 10-cycle stall.
      stall_arm = 1;
      frame_start(0);
      wait_done(6000);
      check("d_cycles", done_cyc, NX + 3 + 10);
      check("d_xfers", n_xfer, NX);
`ifdef SD_DECOMP_PERF_CNT_EN
      check("d_stall_cnt", stall_cnt, 10);
`endif
      repeat (5) cycle();
      check("d_done_once", done_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
